// File: rtl/ras_spec.sv
// ras_spec: speculative return address stack with checkpointed mispredict recovery.
// Define RAS_STATS_EN to build the saturating overflow/underflow counters.
module ras_spec #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              pred_valid,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [XLEN-1:0]   push_addr,
  output logic [XLEN-1:0]   pred_target,
  output logic              pred_target_valid,
  input  logic              ckpt_save,
  input  logic [CKPT_W-1:0] ckpt_save_id,
  input  logic              restore_en,
  input  logic [CKPT_W-1:0] restore_id,
  output logic              ckpt_err,
  output logic [PTR_W-1:0]  tos_out,
  output logic [PTR_W:0]    count_out,
  output logic [15:0]       ovf_cnt,
  output logic [15:0]       unf_cnt
);
  localparam logic [6:0]     OP_J_JAL  = 7'b1101111;
  localparam logic [6:0]     OP_J_JALR = 7'b1100111;
  localparam logic [PTR_W:0] FULL      = (PTR_W + 1)'(DEPTH);
  logic [XLEN-1:0]  r_stack [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W:0]   r_cnt;
  logic [NUM_CKPT-1:0] r_ck_vld;
  logic [PTR_W-1:0] r_ck_tos [NUM_CKPT];
  logic [PTR_W:0]   r_ck_cnt [NUM_CKPT];
  logic [XLEN-1:0]  r_ck_top [NUM_CKPT];
  logic             r_ckpt_err;
  logic w_link_rd, w_link_rs1, w_jal, w_jalr, w_push, w_pop, w_swap;
  logic w_empty, w_full, w_pop_go, w_ck_hit, w_save, w_wr;
  logic [PTR_W-1:0] w_inc, w_dec, w_nxt_tos, w_wr_ptr;
  logic [PTR_W:0]   w_nxt_cnt;
  logic [XLEN-1:0]  w_nxt_top;
  assign w_link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign w_link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign w_jal  = pred_valid && (opcode == OP_J_JAL);
  assign w_jalr = pred_valid && (opcode == OP_J_JALR);
  assign w_push = (w_jal && w_link_rd) || (w_jalr && w_link_rd && (!w_link_rs1 || rd == rs1));
  assign w_pop  = w_jalr && !w_link_rd && w_link_rs1;
  assign w_swap = w_jalr && w_link_rd && w_link_rs1 && (rd != rs1);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == FULL);
  assign w_pop_go = w_pop && !w_empty;
  assign w_inc = r_tos + PTR_W'(1);
  assign w_dec = r_tos - PTR_W'(1);
  assign w_nxt_tos = w_push ? w_inc : w_pop_go ? w_dec : r_tos;
  assign w_nxt_cnt = w_push ? (w_full ? r_cnt : r_cnt + (PTR_W + 1)'(1))
                   : w_pop_go ? r_cnt - (PTR_W + 1)'(1)
                   : (w_swap && w_empty) ? (PTR_W + 1)'(1) : r_cnt;
  assign w_wr      = w_push || w_swap;
  assign w_wr_ptr  = w_push ? w_inc : r_tos;
  // A checkpoint captures the post-update top, so forward the write data.
  assign w_nxt_top = w_wr ? push_addr : r_stack[w_nxt_tos];
  assign w_ck_hit  = restore_en && r_ck_vld[restore_id];
  assign w_save    = ckpt_save && !restore_en;
  assign pred_target       = r_stack[r_tos];
  assign pred_target_valid = (w_pop || w_swap) && !w_empty;
  assign ckpt_err  = r_ckpt_err;
  assign tos_out   = r_tos;
  assign count_out = r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_stack[k] <= '0;
      r_tos      <= '0;
      r_cnt      <= '0;
      r_ck_vld   <= '0;
      r_ckpt_err <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) r_stack[k] <= '0;
      r_tos      <= '0;
      r_cnt      <= '0;
      r_ck_vld   <= '0;
      r_ckpt_err <= 1'b0;
    end else begin
      r_ckpt_err <= restore_en && !r_ck_vld[restore_id];
      if (w_ck_hit) begin
        r_tos                          <= r_ck_tos[restore_id];
        r_cnt                          <= r_ck_cnt[restore_id];
        r_stack[r_ck_tos[restore_id]]  <= r_ck_top[restore_id];
        r_ck_vld[restore_id]           <= 1'b0;
      end else begin
        r_tos <= w_nxt_tos;
        r_cnt <= w_nxt_cnt;
        if (w_wr) r_stack[w_wr_ptr] <= push_addr;
        if (w_save) r_ck_vld[ckpt_save_id] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_save) begin
      r_ck_tos[ckpt_save_id] <= w_nxt_tos;
      r_ck_cnt[ckpt_save_id] <= w_nxt_cnt;
      r_ck_top[ckpt_save_id] <= w_nxt_top;
    end
  end
`ifdef RAS_STATS_EN
  logic [15:0] r_ovf, r_unf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= '0;
      r_unf <= '0;
    end else if (flush) begin
      r_ovf <= '0;
      r_unf <= '0;
    end else if (!w_ck_hit) begin
      if (w_push && w_full && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
      if ((w_pop || w_swap) && w_empty && r_unf != 16'hFFFF) r_unf <= r_unf + 16'd1;
    end
  end
  assign ovf_cnt = r_ovf;
  assign unf_cnt = r_unf;
`else
  assign ovf_cnt = '0;
  assign unf_cnt = '0;
`endif
endmodule

// File: tb/tb_ras_spec.sv
// tb_ras_spec: randomized + directed scoreboard bench for ras_spec against an array-based model.
module tb_ras_spec;
  localparam int DEPTH = 8;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  logic clk = 0, reset = 1, flush = 0, pred_valid = 0;
  logic [6:0] opcode = 0;
  logic [4:0] rd = 0, rs1 = 0;
  logic [31:0] push_addr = 0;
  logic ckpt_save = 0, restore_en = 0;
  logic [1:0] ckpt_save_id = 0, restore_id = 0;
  logic [31:0] pred_target;
  logic pred_target_valid, ckpt_err;
  logic [2:0] tos_out;
  logic [3:0] count_out;
  logic [15:0] ovf_cnt, unf_cnt;
  ras_spec dut (
    .clk(clk), .reset(reset), .flush(flush), .pred_valid(pred_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .push_addr(push_addr), .pred_target(pred_target),
    .pred_target_valid(pred_target_valid), .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .restore_en(restore_en), .restore_id(restore_id), .ckpt_err(ckpt_err), .tos_out(tos_out),
    .count_out(count_out), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );
  always #5 clk = ~clk;
  logic [31:0] m_stk [DEPTH];
  int m_tos, m_cnt, m_ovf, m_unf;
  bit m_err;
  bit c_v [4];
  int c_tos [4], c_cnt [4];
  logic [31:0] c_top [4];
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [31:0] pt;
    bit pv;
    int tos, cnt;
    bit err;
    int ovf, unf;
  } exp_t;
  exp_t sb [$];
  exp_t me;
  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int decode(logic v, logic [6:0] o, logic [4:0] d, logic [4:0] s);
    bit ld = (d == 5'd1) || (d == 5'd5);
    bit ls = (s == 5'd1) || (s == 5'd5);
    if (!v) return 0;
    if (o == JAL) return ld ? 1 : 0;
    if (o != JALR) return 0;
    if (ld && !ls) return 1;
    if (!ld && ls) return 2;
    if (ld && ls) return (d == s) ? 1 : 3;
    return 0;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
    for (int i = 0; i < 4; i++) c_v[i] = 0;
    m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_err = 0;
  endtask
  task automatic model_step(int op);
    bit hit = restore_en && c_v[restore_id];
    if (flush) begin
      model_clear();
      return;
    end
    if (hit) begin
      m_tos = c_tos[restore_id];
      m_cnt = c_cnt[restore_id];
      m_stk[m_tos] = c_top[restore_id];
      c_v[restore_id] = 0;
    end else begin
      case (op)
        1: begin
          if (m_cnt == DEPTH && m_ovf < 65535) m_ovf++;
          m_tos = (m_tos + 1) % DEPTH;
          m_stk[m_tos] = push_addr;
          if (m_cnt < DEPTH) m_cnt++;
        end
        2: begin
          if (m_cnt == 0) begin
            if (m_unf < 65535) m_unf++;
          end else begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_cnt--;
          end
        end
        3: begin
          if (m_cnt == 0) begin
            if (m_unf < 65535) m_unf++;
            m_cnt = 1;
          end
          m_stk[m_tos] = push_addr;
        end
        default: ;
      endcase
      if (ckpt_save && !restore_en) begin
        c_v[ckpt_save_id]   = 1;
        c_tos[ckpt_save_id] = m_tos;
        c_cnt[ckpt_save_id] = m_cnt;
        c_top[ckpt_save_id] = m_stk[m_tos];
      end
    end
    m_err = restore_en && !hit;
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("pred_target", pred_target, me.pt);
      chk("pred_target_valid", 32'(pred_target_valid), 32'(me.pv));
      chk("tos_out", 32'(tos_out), 32'(me.tos));
      chk("count_out", 32'(count_out), 32'(me.cnt));
      chk("ckpt_err", 32'(ckpt_err), 32'(me.err));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(me.ovf));
      chk("unf_cnt", 32'(unf_cnt), 32'(me.unf));
    end
  end
  task automatic cycle();
    int op;
    exp_t e;
    if (reset) model_clear();
    op = decode(pred_valid, opcode, rd, rs1);
    e.pt  = m_stk[m_tos];
    e.pv  = (op == 2 || op == 3) && m_cnt != 0;
    e.tos = m_tos;
    e.cnt = m_cnt;
    e.err = m_err;
`ifdef RAS_STATS_EN
    e.ovf = m_ovf;
    e.unf = m_unf;
`else
    e.ovf = 0;
    e.unf = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    if (!reset) model_step(op);
    #1;
    reset = 0; flush = 0; pred_valid = 0; opcode = 0; rd = 0; rs1 = 0;
    ckpt_save = 0; restore_en = 0;
  endtask
  task automatic setop(logic [6:0] o, logic [4:0] d, logic [4:0] s, logic [31:0] a);
    pred_valid = 1; opcode = o; rd = d; rs1 = s; push_addr = a;
  endtask
  task automatic call(logic [31:0] a);
    setop(JAL, 5'd1, 5'd0, a);
    cycle();
  endtask
  task automatic ret();
    setop(JALR, 5'd0, 5'd1, 32'h0);
    cycle();
  endtask
  function automatic logic [4:0] pick_reg();
    int r = $urandom_range(0, 3);
    return r == 0 ? 5'd1 : r == 1 ? 5'd5 : r == 2 ? 5'd0 : 5'($urandom_range(0, 31));
  endfunction
  initial begin
    int r;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1;
    cycle();
    cycle();
    call(32'h100); call(32'h200); call(32'h300);
    ret(); ret(); ret();
    for (int i = 1; i <= 9; i++) call(32'(i * 16));
    for (int i = 0; i < 9; i++) ret();
    flush = 1; cycle();
    call(32'hA0); call(32'hB0);
    setop(JALR, 5'd1, 5'd5, 32'hC0); cycle();
    ret(); ret();
    call(32'h40); call(32'h50);
    ckpt_save = 1; ckpt_save_id = 2; cycle();
    ret(); ret(); call(32'h99);
    restore_en = 1; restore_id = 2; cycle();
    ret(); ret();
    restore_en = 1; restore_id = 3; setop(JAL, 5'd1, 5'd0, 32'h77); cycle();
    cycle(); cycle();
    ckpt_save = 1; ckpt_save_id = 1; call(32'h11);
    call(32'h22);
    flush = 1; setop(JAL, 5'd1, 5'd0, 32'h33); cycle();
    cycle();
    restore_en = 1; restore_id = 1; cycle();
    cycle();
    call(32'h44); call(32'h55);
    reset = 1; setop(JAL, 5'd1, 5'd0, 32'h66); cycle();
    cycle();
    for (int i = 0; i < 800; i++) begin
      pred_valid = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 3);
      opcode = r == 0 ? JAL : r == 3 ? 7'($urandom) : JALR;
      rd = pick_reg();
      rs1 = pick_reg();
      push_addr = $urandom;
      ckpt_save = $urandom_range(0, 3) == 0;
      ckpt_save_id = 2'($urandom);
      restore_en = $urandom_range(0, 5) == 0;
      restore_id = 2'($urandom);
      flush = $urandom_range(0, 59) == 0;
      reset = $urandom_range(0, 149) == 0;
      cycle();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
